// File: rtl/hram_pkg.sv
// Shared types and command-address helpers for the HyperRAM burst engine.
package hram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_WAIT,
    ST_WDATA,
    ST_RDATA,
    ST_PAD,
    ST_CSHI
  } hram_state_t;

  localparam int CA_RW    = 47;
  localparam int CA_AS    = 46;
  localparam int CA_BT    = 45;
  localparam int CA_BYTES = 6;

  // Linear-burst CA word; half-word address split into row/upper and column bits.
  function automatic logic [47:0] build_ca(input logic write, input logic regspace,
                                           input logic [31:0] addr);
    logic [47:0] ca;
    ca         = '0;
    ca[CA_RW]  = ~write;
    ca[CA_AS]  = regspace;
    ca[CA_BT]  = 1'b1;
    ca[44:16]  = addr[31:3];
    ca[2:0]    = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hram_rd_capture.sv
// Read-side capture: RWDS edge detect, byte pairing into 16-bit words, and the
// no-edge timeout. Held cleared whenever clr is high.
module hram_rd_capture #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        clr,
  input  logic        rwds_din,
  input  logic [7:0]  dq_din,
  output logic        word_done,
  output logic        tmo_hit,
  output logic        rdata_valid,
  output logic [15:0] rdata,
  output logic        err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          rwds_q;
  logic          rwds_edge;
  logic          have_hi;
  logic [7:0]    hi_q;
  logic [TW-1:0] tmo_cnt;

  // Either RWDS transition marks a valid byte on DQ in the same cycle.
  assign rwds_edge = rwds_din != rwds_q;
  assign word_done = en && rwds_edge && have_hi;
  assign tmo_hit   = en && !rwds_edge && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rwds_q      <= 1'b0;
      have_hi     <= 1'b0;
      hi_q        <= 8'h00;
      tmo_cnt     <= '0;
      rdata       <= 16'h0000;
      rdata_valid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rwds_q      <= rwds_din;
      rdata_valid <= 1'b0;
      err_timeout <= tmo_hit;
      if (clr) begin
        have_hi <= 1'b0;
        tmo_cnt <= '0;
      end else if (en) begin
        if (rwds_edge) begin
          tmo_cnt <= '0;
          if (!have_hi) begin
            hi_q    <= dq_din;
            have_hi <= 1'b1;
          end else begin
            rdata       <= {hi_q, dq_din};
            rdata_valid <= 1'b1;
            have_hi     <= 1'b0;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hram_burst_ctrl.sv
// Command-driven HyperRAM burst engine: CA phase, fixed 2x latency wait, then
// a write or read word stream, with CS high recovery between transactions.
module hram_burst_ctrl
  import hram_pkg::*;
#(
  parameter int LATENCY   = 6,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 64,
  parameter int CSHI_CLKS = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic                 cmd_regspace,
  input  logic [31:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [15:0]          wdata,
  output logic                 rdata_valid,
  output logic [15:0]          rdata,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 underrun,
  output logic                 hram_ck,
  output logic                 hram_cs,
  output logic                 hram_rwds_dir,
  output logic                 hram_rwds_dout,
  input  logic                 hram_rwds_din,
  output logic                 hram_dq_dir,
  output logic [7:0]           hram_dq_dout,
  input  logic [7:0]           hram_dq_din,
  output hram_state_t          state_dbg
);
  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
  // a write word transfers where wdata_ready is high (it already implies
  // wdata_valid); rdata_valid is a pulse with no backpressure.
  localparam int WAIT_CLKS = 4 * LATENCY;
  localparam int CNT_W     = 16;

  hram_state_t          state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [47:0]          ca_q;
  logic [LEN_WIDTH-1:0] words_left;
  logic                 is_write, regspace, phase, mask_q, tmo_seen;
  logic                 ck_q, ck_n, done_n;
  logic [7:0]           lo_q;
  logic                 rd_en, word_done, tmo_hit;

  assign rd_en     = state == ST_RDATA;
  assign hram_ck   = ck_q;
  assign state_dbg = state;

  hram_rd_capture #(.TIMEOUT(TIMEOUT)) u_rd_capture (
    .clk        (clk),
    .resetn     (resetn),
    .en         (rd_en),
    .clr        (!rd_en),
    .rwds_din   (hram_rwds_din),
    .dq_din     (hram_dq_din),
    .word_done  (word_done),
    .tmo_hit    (tmo_hit),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .err_timeout(err_timeout)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      ck_q       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      ca_q       <= '0;
      words_left <= '0;
      is_write   <= 1'b0;
      regspace   <= 1'b0;
      phase      <= 1'b0;
      mask_q     <= 1'b0;
      lo_q       <= 8'h00;
      tmo_seen   <= 1'b0;
    end else begin
      state <= state_n;
      ck_q  <= ck_n;
      done  <= done_n;
      cnt   <= (state_n == state) ? cnt + 1'b1 : '0;
      case (state)
        ST_IDLE: begin
          phase    <= 1'b0;
          tmo_seen <= 1'b0;
          if (cmd_valid) begin
            ca_q       <= build_ca(cmd_write, cmd_regspace, cmd_addr);
            words_left <= cmd_len;
            is_write   <= cmd_write;
            regspace   <= cmd_regspace;
          end
        end
        ST_CA: ca_q <= {ca_q[39:0], 8'h00};
        ST_WDATA: begin
          phase <= ~phase;
          if (!phase) begin
            lo_q   <= wdata_valid ? wdata[7:0] : 8'h00;
            mask_q <= ~wdata_valid;
          end else begin
            words_left <= words_left - 1'b1;
          end
        end
        ST_RDATA: begin
          if (word_done) words_left <= words_left - 1'b1;
          if (tmo_hit) tmo_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    cmd_ready      = 1'b0;
    wdata_ready    = 1'b0;
    underrun       = 1'b0;
    hram_cs        = 1'b1;
    hram_dq_dir    = 1'b0;
    hram_dq_dout   = 8'h00;
    hram_rwds_dir  = 1'b0;
    hram_rwds_dout = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = resetn;
        if (cmd_valid) state_n = ST_CA;
      end
      ST_CA: begin
        hram_cs      = 1'b0;
        hram_dq_dir  = 1'b1;
        hram_dq_dout = ca_q[47:40];
        if (cnt == CNT_W'(CA_BYTES - 1)) state_n = (is_write && regspace) ? ST_WDATA : ST_WAIT;
      end
      ST_WAIT: begin
        hram_cs = 1'b0;
        if (cnt == CNT_W'(WAIT_CLKS - 1)) state_n = is_write ? ST_WDATA : ST_RDATA;
      end
      ST_WDATA: begin
        hram_cs       = 1'b0;
        hram_dq_dir   = 1'b1;
        hram_rwds_dir = !regspace;
        if (!phase) begin
          wdata_ready    = wdata_valid;
          underrun       = !wdata_valid;
          hram_dq_dout   = wdata_valid ? wdata[15:8] : 8'h00;
          hram_rwds_dout = !regspace && !wdata_valid;
        end else begin
          hram_dq_dout   = lo_q;
          hram_rwds_dout = !regspace && mask_q;
          if (words_left == '0) state_n = ck_q ? ST_PAD : ST_CSHI;
        end
      end
      ST_RDATA: begin
        hram_cs = 1'b0;
        if ((word_done && words_left == '0) || tmo_hit) state_n = ck_q ? ST_PAD : ST_CSHI;
      end
      ST_PAD: begin
        hram_cs = 1'b0;
        state_n = ST_CSHI;
      end
      ST_CSHI: begin
        if (cnt == CNT_W'(CSHI_CLKS - 1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // CK runs in every CS-low state; leaving it toggling into PAD lands it at 0.
    ck_n   = (state_n inside {ST_CA, ST_WAIT, ST_WDATA, ST_RDATA, ST_PAD}) ? ~ck_q : 1'b0;
    done_n = (state_n == ST_CSHI) && (state != ST_CSHI) && !tmo_hit && !tmo_seen;
  end

endmodule

// File: tb/tb_hram_burst_ctrl.sv
// Self-checking bench for hram_burst_ctrl: writes, register writes, underrun,
// length wrap, reads with an RWDS device model, read timeout and mid-burst reset.
module tb_hram_burst_ctrl;
  import hram_pkg::*;

  localparam int LATENCY   = 6;
  localparam int LEN_WIDTH = 8;
  localparam int TIMEOUT   = 64;
  localparam int CSHI_CLKS = 4;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_regspace = 1'b0;
  logic [31:0]          cmd_addr = '0;
  logic [LEN_WIDTH-1:0] cmd_len = '0;
  logic                 wdata_valid = 1'b0, wdata_ready;
  logic [15:0]          wdata = '0;
  logic                 rdata_valid, done, err_timeout, underrun;
  logic [15:0]          rdata;
  logic                 hram_ck, hram_cs, hram_rwds_dir, hram_rwds_dout, hram_dq_dir;
  logic                 hram_rwds_din = 1'b0;
  logic [7:0]           hram_dq_dout;
  logic [7:0]           hram_dq_din = '0;
  hram_state_t          state_dbg;

  hram_burst_ctrl #(
    .LATENCY(LATENCY), .LEN_WIDTH(LEN_WIDTH), .TIMEOUT(TIMEOUT), .CSHI_CLKS(CSHI_CLKS)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_regspace(cmd_regspace), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .err_timeout(err_timeout), .underrun(underrun),
    .hram_ck(hram_ck), .hram_cs(hram_cs),
    .hram_rwds_dir(hram_rwds_dir), .hram_rwds_dout(hram_rwds_dout), .hram_rwds_din(hram_rwds_din),
    .hram_dq_dir(hram_dq_dir), .hram_dq_dout(hram_dq_dout), .hram_dq_din(hram_dq_din),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard: bytes are {rwds_dir, rwds_dout, dq}
  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];
  logic [15:0] exp_w_q[$];
  logic [15:0] obs_w_q[$];
  logic [16:0] wsup_q[$];
  logic [7:0]  rd_bytes_q[$];

  int   rd_start;
  int   n_done, n_err, n_under, n_wready, n_busy_ready, wait_cycles, cshi_cycles, err_cycle;
  logic last_ck;
  bit   run_timeout;
  logic ab_cs, ab_ck, ab_dqdir, ab_rwdsdir, ab_ready;

  // driver + collector: issues one command, feeds write words and device read
  // bytes, and records what the DUT produced until it is back in IDLE.
  task automatic run_txn(input logic wr, input logic rs, input logic [31:0] addr,
                         input logic [LEN_WIDTH-1:0] len, input int abort_at);
    int  k;
    bit  accepted, saw_cs, adv, fin;
    k = -1; accepted = 0; saw_cs = 0; fin = 0;
    n_done = 0; n_err = 0; n_under = 0; n_wready = 0; n_busy_ready = 0;
    wait_cycles = 0; cshi_cycles = 0; err_cycle = -1; last_ck = 1'bx;
    obs_q.delete(); obs_w_q.delete();
    cmd_write = wr; cmd_regspace = rs; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    if (wsup_q.size() > 0) begin
      wdata_valid = wsup_q[0][16]; wdata = wsup_q[0][15:0];
    end else wdata_valid = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk);
      adv = 0;
      if (accepted) begin
        k++;
        if (!hram_cs) begin
          saw_cs = 1; last_ck = hram_ck;
          if (cmd_ready) n_busy_ready++;
          if (hram_dq_dir) obs_q.push_back({hram_rwds_dir, hram_rwds_dout, hram_dq_dout});
          else wait_cycles++;
        end else if (saw_cs && !cmd_ready) cshi_cycles++;
        if (done) n_done++;
        if (err_timeout) begin n_err++; err_cycle = k; end
        if (underrun) n_under++;
        if (wdata_ready) n_wready++;
        if (rdata_valid) obs_w_q.push_back(rdata);
        if (wdata_ready || underrun) adv = 1;
        if (saw_cs && hram_cs && cmd_ready) fin = 1;
      end else if (cmd_valid && cmd_ready) accepted = 1;
      if (!fin) begin
        @(posedge clk); #1;
        if (accepted) cmd_valid = 1'b0;
        if (adv && wsup_q.size() > 0) begin
          void'(wsup_q.pop_front());
          if (wsup_q.size() > 0) begin
            wdata_valid = wsup_q[0][16]; wdata = wsup_q[0][15:0];
          end else wdata_valid = 1'b0;
        end
        if (accepted && k >= rd_start && rd_bytes_q.size() > 0) begin
          hram_dq_din   = rd_bytes_q.pop_front();
          hram_rwds_din = ~hram_rwds_din;
        end
        if (abort_at >= 0 && k == abort_at) begin
          resetn = 1'b0;
          @(negedge clk);
          if (done) n_done++;
          if (err_timeout) n_err++;
          @(negedge clk);
          if (done) n_done++;
          if (err_timeout) n_err++;
          ab_cs = hram_cs; ab_ck = hram_ck; ab_dqdir = hram_dq_dir;
          ab_rwdsdir = hram_rwds_dir; ab_ready = cmd_ready;
          fin = 1;
        end
      end
    end
    run_timeout = !fin;
    cmd_valid = 1'b0;
    wsup_q.delete(); rd_bytes_q.delete();
  endtask

  task automatic push_bytes(input logic [1:0] rw, input logic [47:0] bytes, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({rw, bytes[i*8 +: 8]});
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hram_cs, hram_ck, hram_dq_dir, hram_rwds_dir} !== 4'b1000) begin
      failures++; $display("FAIL rst_pins got=%b exp=1000", {hram_cs, hram_ck, hram_dq_dir, hram_rwds_dir});
    end
    checks++;
    if ({hram_dq_dout, hram_rwds_dout} !== 9'h000) begin
      failures++; $display("FAIL rst_dout got=%h exp=000", {hram_dq_dout, hram_rwds_dout});
    end
    checks++;
    if ({cmd_ready, done, err_timeout, underrun, rdata_valid, wdata_ready} !== 6'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=000000",
                           {cmd_ready, done, err_timeout, underrun, rdata_valid, wdata_ready});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    logic [9:0] e, o;
    push_bytes(2'b00, 48'h2000_0246_0004, 6);
    push_bytes(2'b10, 48'h0000_A55A_0FF0, 4);
    wsup_q.push_back({1'b1, 16'hA55A}); wsup_q.push_back({1'b1, 16'h0FF0});
    rd_start = 100000;
    run_txn(1'b1, 1'b0, 32'h0000_1234, 8'd1, -1);
    checks++;
    if (run_timeout) begin failures++; $display("FAIL wr_run timed out got=1 exp=0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3ff;
      if (o !== e) begin failures++; $display("FAIL wr_byte got=%03h exp=%03h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL wr_extra got=%0d exp=0", obs_q.size()); end
    checks++;
    if (wait_cycles != 4 * LATENCY) begin failures++; $display("FAIL wr_wait got=%0d exp=%0d", wait_cycles, 4 * LATENCY); end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL wr_done got=%0d exp=1", n_done); end
    checks++;
    if (n_wready != 2 || n_under != 0) begin
      failures++; $display("FAIL wr_ready got=%0d/%0d exp=2/0", n_wready, n_under);
    end
    checks++;
    if (cshi_cycles != CSHI_CLKS) begin failures++; $display("FAIL wr_cshi got=%0d exp=%0d", cshi_cycles, CSHI_CLKS); end
    checks++;
    if (last_ck !== 1'b0 || n_busy_ready != 0) begin
      failures++; $display("FAIL wr_ck_busy got=%b/%0d exp=0/0", last_ck, n_busy_ready);
    end
  endtask

  task automatic test_reg_write();
    logic [9:0] e, o;
    push_bytes(2'b00, 48'h6000_0000_0000, 6);
    push_bytes(2'b00, 48'h0000_0000_8F1F, 2);
    wsup_q.push_back({1'b1, 16'h8F1F});
    rd_start = 100000;
    run_txn(1'b1, 1'b1, 32'h0, 8'd0, -1);
    checks++;
    if (run_timeout) begin failures++; $display("FAIL reg_run timed out got=1 exp=0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3ff;
      if (o !== e) begin failures++; $display("FAIL reg_byte got=%03h exp=%03h", o, e); end
    end
    checks++;
    if (wait_cycles != 0) begin failures++; $display("FAIL reg_wait got=%0d exp=0", wait_cycles); end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL reg_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_underrun();
    logic [9:0] e, o;
    push_bytes(2'b00, 48'h2000_0008_0000, 6);
    push_bytes(2'b10, 48'h0000_0000_1111, 2);
    push_bytes(2'b11, 48'h0000_0000_0000, 2);
    push_bytes(2'b10, 48'h0000_0000_3333, 2);
    wsup_q.push_back({1'b1, 16'h1111}); wsup_q.push_back({1'b0, 16'hDEAD});
    wsup_q.push_back({1'b1, 16'h3333});
    rd_start = 100000;
    run_txn(1'b1, 1'b0, 32'h40, 8'd2, -1);
    checks++;
    if (run_timeout) begin failures++; $display("FAIL und_run timed out got=1 exp=0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3ff;
      if (o !== e) begin failures++; $display("FAIL und_byte got=%03h exp=%03h", o, e); end
    end
    checks++;
    if (n_under != 1 || n_wready != 2) begin
      failures++; $display("FAIL und_count got=%0d/%0d exp=1/2", n_under, n_wready);
    end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL und_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_len_wrap();
    logic [9:0]  e, o;
    logic [15:0] w;
    int          nbad;
    push_bytes(2'b00, 48'h2000_0000_0000, 6);
    for (int i = 0; i < 256; i++) begin
      w = 16'(i * 259 + 5);
      exp_q.push_back({2'b10, w[15:8]}); exp_q.push_back({2'b10, w[7:0]});
      wsup_q.push_back({1'b1, w});
    end
    rd_start = 100000;
    run_txn(1'b1, 1'b0, 32'h0, 8'hFF, -1);
    checks++;
    if (run_timeout) begin failures++; $display("FAIL wrap_run timed out got=1 exp=0"); end
    nbad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3ff;
      if (o !== e) nbad++;
    end
    checks++;
    if (nbad != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL wrap_bytes got=%0d bad/%0d extra exp=0/0", nbad, obs_q.size());
    end
    checks++;
    if (n_wready != 256 || n_done != 1) begin
      failures++; $display("FAIL wrap_words got=%0d/%0d exp=256/1", n_wready, n_done);
    end
  endtask

  task automatic test_read(input logic [31:0] addr, input logic [47:0] ca,
                           input logic [15:0] word);
    logic [9:0]  e, o;
    logic [15:0] ew, ow;
    push_bytes(2'b00, ca, 6);
    exp_w_q.push_back(word);
    rd_bytes_q.push_back(word[15:8]); rd_bytes_q.push_back(word[7:0]);
    rd_start = 32;
    run_txn(1'b0, 1'b0, addr, 8'd0, -1);
    checks++;
    if (run_timeout) begin failures++; $display("FAIL rd_run timed out got=1 exp=0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3ff;
      if (o !== e) begin failures++; $display("FAIL rd_ca got=%03h exp=%03h", o, e); end
    end
    while (exp_w_q.size() > 0) begin
      ew = exp_w_q.pop_front(); checks++;
      ow = (obs_w_q.size() > 0) ? obs_w_q.pop_front() : 16'hxxxx;
      if (ow !== ew) begin failures++; $display("FAIL rd_word got=%04h exp=%04h", ow, ew); end
    end
    checks++;
    if (obs_w_q.size() != 0) begin failures++; $display("FAIL rd_extra got=%0d exp=0", obs_w_q.size()); end
    checks++;
    if (n_done != 1 || n_err != 0) begin failures++; $display("FAIL rd_done got=%0d/%0d exp=1/0", n_done, n_err); end
    checks++;
    if (last_ck !== 1'b0) begin failures++; $display("FAIL rd_ck_end got=%b exp=0", last_ck); end
  endtask

  task automatic test_timeout();
    rd_start = 100000;
    run_txn(1'b0, 1'b0, 32'h0, 8'd0, -1);
    checks++;
    if (run_timeout) begin failures++; $display("FAIL tmo_run timed out got=1 exp=0"); end
    checks++;
    if (n_err != 1 || err_cycle != CA_BYTES + 4 * LATENCY + TIMEOUT) begin
      failures++; $display("FAIL tmo_err got=%0d@%0d exp=1@%0d", n_err, err_cycle,
                           CA_BYTES + 4 * LATENCY + TIMEOUT);
    end
    checks++;
    if (n_done != 0 || obs_w_q.size() != 0) begin
      failures++; $display("FAIL tmo_done got=%0d/%0d exp=0/0", n_done, obs_w_q.size());
    end
    checks++;
    if (cshi_cycles != CSHI_CLKS) begin failures++; $display("FAIL tmo_cshi got=%0d exp=%0d", cshi_cycles, CSHI_CLKS); end
  endtask

  task automatic test_reset_mid_read();
    rd_start = 100000;
    run_txn(1'b0, 1'b0, 32'h0, 8'd0, 40);
    checks++;
    if ({ab_cs, ab_ck, ab_dqdir, ab_rwdsdir, ab_ready} !== 5'b10000) begin
      failures++; $display("FAIL abort_pins got=%b exp=10000", {ab_cs, ab_ck, ab_dqdir, ab_rwdsdir, ab_ready});
    end
    checks++;
    if (n_done != 0 || n_err != 0) begin failures++; $display("FAIL abort_pulse got=%0d/%0d exp=0/0", n_done, n_err); end
    resetn = 1'b1;
    @(posedge clk); #1;
    test_read(32'h20, 48'hA000_0004_0000, 16'h1234);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_reg_write();
    test_underrun();
    test_read(32'h10, 48'hA000_0002_0000, 16'hBEEF);
    test_timeout();
    test_reset_mid_read();
    test_len_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hram_burst_ctrl.md
Name: hram_burst_ctrl

Overview:
Parametrised HyperRAM transaction engine that replaces fixed-pattern pin playback with command-driven bursts. Accepts read/write commands over a valid/ready interface, builds the 48-bit command-address (CA), inserts latency, and streams 16-bit words. Writes take a word stream and reads produce one. Sits between the application/host bridge and the HRAM SB_IO pin registers. The pin-level signals are clk-domain registers; CK toggles at half the clk rate.

Parameters:
LATENCY, 6, initial latency in CK cycles; the wait phase lasts 4*LATENCY clk (fixed 2x latency).
LEN_WIDTH, 8, width of cmd_len; a burst is cmd_len+1 words.
TIMEOUT, 64, clk cycles without an RWDS edge before a read aborts.
CSHI_CLKS, 4, minimum clk cycles CS stays high between transactions (>=1).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_regspace  in  1  CA[46] register space
cmd_addr  in  32  half-word address
cmd_len  in  LEN_WIDTH  words minus one
wdata_valid  in  1  write word offered
wdata_ready  out  1  write word accepted this cycle
wdata  in  16  write word, [15:8] sent first
rdata_valid  out  1  one-cycle pulse, no backpressure
rdata  out  16  read word, first byte in [15:8]
done  out  1  one-cycle pulse on successful completion
err_timeout  out  1  one-cycle pulse on read abort
underrun  out  1  one-cycle pulse per masked write word
hram_ck  out  1  HRAM CK
hram_cs  out  1  HRAM CS#, active low
hram_rwds_dir  out  1  RWDS output enable
hram_rwds_dout  out  1  RWDS drive value (write mask)
hram_rwds_din  in  1  RWDS sampled input
hram_dq_dir  out  1  DQ output enable
hram_dq_dout  out  8  DQ drive value
hram_dq_din  in  8  DQ sampled input

Behaviour:
- Clock and reset:
  - Clock is clk. Reset is resetn, synchronous, active-low.
  - Reset values: state IDLE, hram_cs=1, hram_ck=0, all dir=0, hram_dq_dout=0, hram_rwds_dout=0, cmd_ready=0 during reset, all pulses=0.
  - Reset asserted mid-burst takes effect on the next edge. CS goes high and the transaction is dropped with no done/err.
- States: IDLE -> CA -> (WAIT) -> WDATA | RDATA -> CSHI -> IDLE.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch command and word count, go to CA.
- CA (6 clk):
  - hram_cs=0, dq_dir=1, hram_ck toggles every clk (1 on the first CA cycle).
  - Bytes sent MSB first.
  - CA[47]=~cmd_write, CA[46]=cmd_regspace, CA[45]=1 (linear), CA[44:16]=addr[31:3], CA[15:3]=0, CA[2:0]=addr[2:0].
- Wait decision after CA:
  - Register-space write: no WAIT, go straight to WDATA.
  - Otherwise go to WAIT for 4*LATENCY clk with dq_dir=0 and CK still toggling.
- WDATA:
  - dq_dir=1, rwds_dir=1. Two clk per word: upper byte, then lower byte.
  - wdata_ready pulses on the first clk of each word only if wdata_valid.
  - Word unavailable: drive 0x00 with rwds_dout=1 (masked) for both bytes, pulse underrun, address still advances.
  - Register-space writes ignore masking; rwds_dir=0 there.
- RDATA:
  - dq_dir=0, CK toggles. rwds_din is registered; each cycle where it differs from its previous value captures dq_din.
  - The first capture of a pair goes to [15:8], the second completes the word. rdata_valid pulses the cycle after the second capture.
  - Timeout counter clears on each capture. Reaching TIMEOUT pulses err_timeout and goes to CSHI.
- Burst end:
  - After the last word, go to CSHI.
  - The CK level in the final cycle must be 0 before CS rises. Add one padding cycle if it is not.
- CSHI:
  - cs=1, ck=0, dirs=0 for CSHI_CLKS clk. done pulses on entry unless timed out.
- Commands presented outside IDLE are not accepted (cmd_ready=0). Word count wrap: cmd_len=all-ones gives 2^LEN_WIDTH words.

Decomposition:
- Package hram_pkg holds:
  - the state enumeration;
  - CA bit positions (CA_RW=47, CA_AS=46, CA_BT=45);
  - the CA_BYTES=6 constant;
  - the function building the 48-bit CA from cmd fields.
- Sub-module hram_rd_capture handles the RWDS edge detect, byte pairing, timeout counter, rdata/rdata_valid and timeout flag. It is enabled by the top FSM in RDATA and cleared on entry.

Test Plan:
- Write, cmd_addr=0x00001234, len=1, words 0xA55A,0x0FF0 always valid -> CA bytes 20 00 02 46 00 04, then WAIT of 24 clk, then DQ A5 5A 0F F0 with rwds_dout=0, done=1 once.
- Read, addr=0x10, len=0, model toggles RWDS with bytes 0xBE,0xEF -> rdata=0xBEEF with a single rdata_valid pulse, then done.
- Register write (regspace=1), word 0x8F1F -> CA[47:45]=011, data starts directly after CA with no WAIT, rwds_dir=0.
- Write len=2 with wdata_valid low for the second word -> second word driven 00 00 with rwds_dout=1, underrun pulses once, third word sent normally.
- Read with RWDS never toggling -> err_timeout pulses TIMEOUT clk after WAIT ends, no done, cs=1 for CSHI_CLKS, cmd_ready returns.
- resetn low during RDATA, then high -> next edge cs=1, ck=0, dirs=0; a following read to 0x20 completes with correct data.
